// File: rtl/jtframe_romrq_pkg.sv
// Shared types and constants for the two-slot SDRAM ROM requester.
package jtframe_romrq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_RDY = 2'd2
  } romrq_state_t;

  localparam int         SDRAM_AW    = 22;
  localparam logic [7:0] TIMEOUT_LIM = 8'd255;

  // Word address of the 32-bit pair holding a tag: offset + tag*2, wrapping at 2^22.
  function automatic logic [SDRAM_AW-1:0] req_addr(input logic [SDRAM_AW-1:0] offset,
                                                   input logic [SDRAM_AW-1:0] tag_ext);
    return offset + (tag_ext << 1);
  endfunction

endpackage

// File: rtl/jtframe_romrq_2slot_if.sv
// SDRAM read-port bundle: master is the game-side requester, slave the SDRAM controller.
interface jtframe_romrq_2slot_if;
  import jtframe_romrq_pkg::*;

  logic                sdram_req;
  logic [SDRAM_AW-1:0] sdram_addr;
  logic [1:0]          sdram_bank;
  logic                sdram_ack;
  logic                data_rdy;
  logic [31:0]         data_read;

  modport master (
    output sdram_req, sdram_addr, sdram_bank,
    input  sdram_ack, data_rdy, data_read
  );

  modport slave (
    input  sdram_req, sdram_addr, sdram_bank,
    output sdram_ack, data_rdy, data_read
  );

endinterface

// File: rtl/jtframe_romrq_slot.sv
// One-word (32-bit) ROM cache for a single slot: tag/valid/data, hit compare and halfword select.
module jtframe_romrq_slot #(
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          wr,
  input  logic [AW-2:0] wr_tag,
  input  logic [31:0]   wr_data,
  output logic          ok,
  output logic [15:0]   dout,
  output logic [AW-2:0] tag
);

  logic          valid_q, valid_d;
  logic [AW-2:0] tag_q, tag_d;
  logic [31:0]   data_q, data_d;

  assign tag = addr[AW-1:1];

  // Invalidation wins over a completing write, so data returned during a flush is dropped.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (wr) begin
      valid_d = 1'b1;
      tag_d   = wr_tag;
      data_d  = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign ok   = cs & valid_q & (tag_q == tag);
  assign dout = addr[0] ? data_q[31:16] : data_q[15:0];

endmodule

// File: rtl/jtframe_romrq_2slot.sv
// Two-slot ROM requester toward the SDRAM read port; slot 0 has priority on simultaneous misses.
// Optional JTFRAME_ROMRQ_TIMEOUT_EN adds an 8-bit watchdog that abandons a stalled transaction.
module jtframe_romrq_2slot
  import jtframe_romrq_pkg::*;
#(
  parameter int               SLOT0_AW     = 18,
  parameter int               SLOT1_AW     = 18,
  parameter logic [21:0]      SLOT0_OFFSET = 22'h0,
  parameter logic [21:0]      SLOT1_OFFSET = 22'h0,
  parameter logic [1:0]       SLOT0_BANK   = 2'd0,
  parameter logic [1:0]       SLOT1_BANK   = 2'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  downloading,
  input  logic                  loop_rst,
  input  logic                  slot0_cs,
  input  logic                  slot1_cs,
  input  logic [SLOT0_AW-1:0]   slot0_addr,
  input  logic [SLOT1_AW-1:0]   slot1_addr,
  output logic [15:0]           slot0_dout,
  output logic [15:0]           slot1_dout,
  output logic                  slot0_ok,
  output logic                  slot1_ok,
  jtframe_romrq_2slot_if.master sdram
);

  romrq_state_t        state_q, state_d;
  logic                req_q, req_d;
  logic [SDRAM_AW-1:0] addr_q, addr_d;
  logic [1:0]          bank_q, bank_d;
  logic                owner_q, owner_d;
  logic [SLOT0_AW-2:0] tag0_q, tag0_d;
  logic [SLOT1_AW-2:0] tag1_q, tag1_d;

  logic                complete;
  logic                wr0, wr1;
  logic                clr;
  logic                miss0, miss1;
  logic                timeout;
  logic [SLOT0_AW-2:0] slot0_tag;
  logic [SLOT1_AW-2:0] slot1_tag;

  assign clr = downloading | loop_rst;

  jtframe_romrq_slot #(.AW(SLOT0_AW)) u_slot0 (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .cs      (slot0_cs),
    .addr    (slot0_addr),
    .wr      (wr0),
    .wr_tag  (tag0_q),
    .wr_data (sdram.data_read),
    .ok      (slot0_ok),
    .dout    (slot0_dout),
    .tag     (slot0_tag)
  );

  jtframe_romrq_slot #(.AW(SLOT1_AW)) u_slot1 (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .cs      (slot1_cs),
    .addr    (slot1_addr),
    .wr      (wr1),
    .wr_tag  (tag1_q),
    .wr_data (sdram.data_read),
    .ok      (slot1_ok),
    .dout    (slot1_dout),
    .tag     (slot1_tag)
  );

  assign miss0 = slot0_cs & ~slot0_ok;
  assign miss1 = slot1_cs & ~slot1_ok;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    bank_d   = bank_q;
    owner_d  = owner_q;
    tag0_d   = tag0_q;
    tag1_d   = tag1_q;
    complete = 1'b0;
    if (loop_rst) begin
      state_d = IDLE;
      req_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!downloading && (miss0 || miss1)) begin
            state_d = WAIT_ACK;
            req_d   = 1'b1;
            // Tag is frozen here; the returned word is cached under it even if addr moves.
            if (miss0) begin
              owner_d = 1'b0;
              tag0_d  = slot0_tag;
              addr_d  = req_addr(SLOT0_OFFSET, SDRAM_AW'(slot0_tag));
              bank_d  = SLOT0_BANK;
            end else begin
              owner_d = 1'b1;
              tag1_d  = slot1_tag;
              addr_d  = req_addr(SLOT1_OFFSET, SDRAM_AW'(slot1_tag));
              bank_d  = SLOT1_BANK;
            end
          end
        end
        WAIT_ACK: begin
          if (sdram.sdram_ack) begin
            req_d = 1'b0;
            if (sdram.data_rdy) begin
              complete = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d = WAIT_RDY;
            end
          end else if (timeout) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
        WAIT_RDY: begin
          if (sdram.data_rdy) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else if (timeout) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  assign wr0 = complete & ~owner_q;
  assign wr1 = complete &  owner_q;

`ifdef JTFRAME_ROMRQ_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // Fires on the cycle the count would reach the limit; any state change restarts it.
  assign timeout = (cnt_q + 8'd1) == TIMEOUT_LIM;

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (state_q == IDLE || state_d != state_q) begin
      cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      bank_q  <= 2'd0;
      owner_q <= 1'b0;
      tag0_q  <= '0;
      tag1_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      owner_q <= owner_d;
      tag0_q  <= tag0_d;
      tag1_q  <= tag1_d;
    end
  end

  assign sdram.sdram_req  = req_q;
  assign sdram.sdram_addr = addr_q;
  assign sdram.sdram_bank = bank_q;

endmodule

// File: tb/tb_jtframe_romrq_2slot.sv
// Directed bench for jtframe_romrq_2slot: hand sequences for multi-cycle cases plus a hit table.
module tb_jtframe_romrq_2slot;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic        loop_rst = 1'b0;
  logic        cs0 = 1'b0, cs1 = 1'b0;
  logic [17:0] a0 = '0, a1 = '0;
  logic [15:0] dout0, dout1;
  logic        ok0, ok1;

  int n_chk  = 0;
  int n_pass = 0;
  int hi     = 0;

  jtframe_romrq_2slot_if sdram_if ();

  jtframe_romrq_2slot #(
    .SLOT0_AW     (18),
    .SLOT1_AW     (18),
    .SLOT0_OFFSET (22'h100000),
    .SLOT1_OFFSET (22'h3FFFF8),
    .SLOT0_BANK   (2'd1),
    .SLOT1_BANK   (2'd2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .loop_rst    (loop_rst),
    .slot0_cs    (cs0),
    .slot1_cs    (cs1),
    .slot0_addr  (a0),
    .slot1_addr  (a1),
    .slot0_dout  (dout0),
    .slot1_dout  (dout1),
    .slot0_ok    (ok0),
    .slot1_ok    (ok1),
    .sdram       (sdram_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cs0;
    logic [17:0] a0;
    logic        cs1;
    logic [17:0] a1;
    logic        ok0;
    logic [15:0] d0;
    logic        ok1;
    logic [15:0] d1;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %s = %0h", name, act);
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0] = '{1'b1, 18'h100, 1'b1, 18'h041, 1'b1, 16'h2222, 1'b1, 16'h3333};
    vt[1] = '{1'b1, 18'h101, 1'b1, 18'h040, 1'b1, 16'h1111, 1'b1, 16'h4444};
    vt[2] = '{1'b0, 18'h100, 1'b1, 18'h042, 1'b0, 16'h2222, 1'b0, 16'h4444};
    vt[3] = '{1'b1, 18'h102, 1'b0, 18'h041, 1'b0, 16'h2222, 1'b0, 16'h3333};
    vt[4] = '{1'b1, 18'h004, 1'b1, 18'h141, 1'b0, 16'h2222, 1'b0, 16'h3333};

    sdram_if.sdram_ack = 1'b0;
    sdram_if.data_rdy  = 1'b0;
    sdram_if.data_read = '0;
    cyc();
    cyc();

    chk("rst_req",   sdram_if.sdram_req, 1'b0);
    chk("rst_addr",  sdram_if.sdram_addr, 22'h0);
    chk("rst_bank",  sdram_if.sdram_bank, 2'd0);
    chk("rst_ok0",   ok0, 1'b0);
    chk("rst_ok1",   ok1, 1'b0);
    chk("rst_dout0", dout0, 16'h0);
    chk("rst_dout1", dout1, 16'h0);
    rst = 1'b0;

    // Stray data_rdy while idle must not touch the caches
    sdram_if.data_rdy  = 1'b1;
    sdram_if.data_read = 32'hDEAD_BEEF;
    cyc();
    sdram_if.data_rdy = 1'b0;
    chk("idle_rdy_dout0", dout0, 16'h0);
    chk("idle_rdy_req",   sdram_if.sdram_req, 1'b0);

    // Single miss on slot 0
    cs0 = 1'b1; a0 = 18'h00005;
    #1 chk("t1_miss_ok0", ok0, 1'b0);
    cyc();
    chk("t1_req",  sdram_if.sdram_req, 1'b1);
    chk("t1_addr", sdram_if.sdram_addr, 22'h100004);
    chk("t1_bank", sdram_if.sdram_bank, 2'd1);
    sdram_if.data_rdy  = 1'b1;
    sdram_if.data_read = 32'hDEAD_DEAD;
    cyc();
    sdram_if.data_rdy = 1'b0;
    chk("t1_req_held", sdram_if.sdram_req, 1'b1);
    sdram_if.sdram_ack = 1'b1;
    cyc();
    sdram_if.sdram_ack = 1'b0;
    chk("t1_req_drop", sdram_if.sdram_req, 1'b0);
    cyc();
    cyc();
    sdram_if.data_rdy  = 1'b1;
    sdram_if.data_read = 32'hBEEF_CAFE;
    #1 chk("t1_ok_before_rdy", ok0, 1'b0);
    cyc();
    sdram_if.data_rdy = 1'b0;
    chk("t1_ok0",   ok0, 1'b1);
    chk("t1_dout0", dout0, 16'hBEEF);
    a0 = 18'h00004;
    #1 chk("t1_hit_ok0", ok0, 1'b1);
    chk("t1_hit_dout0", dout0, 16'hCAFE);
    cyc();
    chk("t1_hit_noreq", sdram_if.sdram_req, 1'b0);

    // Simultaneous misses: slot 0 first, slot 1 follows after one idle cycle
    a0 = 18'h100; cs1 = 1'b1; a1 = 18'h041;
    cyc();
    chk("t2_req0",  sdram_if.sdram_req, 1'b1);
    chk("t2_addr0", sdram_if.sdram_addr, 22'h100100);
    chk("t2_bank0", sdram_if.sdram_bank, 2'd1);
    sdram_if.sdram_ack = 1'b1;
    sdram_if.data_rdy  = 1'b1;
    sdram_if.data_read = 32'h1111_2222;
    cyc();
    sdram_if.sdram_ack = 1'b0;
    sdram_if.data_rdy  = 1'b0;
    chk("t2_ok0",      ok0, 1'b1);
    chk("t2_dout0",    dout0, 16'h2222);
    chk("t2_idle_req", sdram_if.sdram_req, 1'b0);
    chk("t2_ok1_pend", ok1, 1'b0);
    cyc();
    chk("t2_req1",  sdram_if.sdram_req, 1'b1);
    chk("t2_addr1", sdram_if.sdram_addr, 22'h000038);
    chk("t2_bank1", sdram_if.sdram_bank, 2'd2);
    sdram_if.sdram_ack = 1'b1;
    cyc();
    sdram_if.sdram_ack = 1'b0;
    cyc();
    sdram_if.data_rdy  = 1'b1;
    sdram_if.data_read = 32'h3333_4444;
    cyc();
    sdram_if.data_rdy = 1'b0;
    chk("t2_ok1",    ok1, 1'b1);
    chk("t2_dout1",  dout1, 16'h3333);
    chk("t2_ok0_end", ok0, 1'b1);

    // Hit/miss table, applied combinationally within one cycle
    for (int i = 0; i < 5; i++) begin
      cs0 = vt[i].cs0; a0 = vt[i].a0;
      cs1 = vt[i].cs1; a1 = vt[i].a1;
      #1;
      chk($sformatf("vec%0d_ok0", i),   ok0,   vt[i].ok0);
      chk($sformatf("vec%0d_dout0", i), dout0, vt[i].d0);
      chk($sformatf("vec%0d_ok1", i),   ok1,   vt[i].ok1);
      chk($sformatf("vec%0d_dout1", i), dout1, vt[i].d1);
    end
    cs0 = 1'b0; cs1 = 1'b0;
    cyc();
    chk("vec_noreq", sdram_if.sdram_req, 1'b0);

    // Slot 1 address moves while the read is in flight
    cs1 = 1'b1; a1 = 18'h010;
    cyc();
    chk("t3_req",  sdram_if.sdram_req, 1'b1);
    chk("t3_addr", sdram_if.sdram_addr, 22'h000008);
    sdram_if.sdram_ack = 1'b1;
    cyc();
    sdram_if.sdram_ack = 1'b0;
    a1 = 18'h020;
    cyc();
    sdram_if.data_rdy  = 1'b1;
    sdram_if.data_read = 32'h5555_6666;
    cyc();
    sdram_if.data_rdy = 1'b0;
    #1 chk("t3_ok1_new", ok1, 1'b0);
    a1 = 18'h011;
    #1 chk("t3_oldtag_ok1", ok1, 1'b1);
    chk("t3_oldtag_dout1", dout1, 16'h5555);
    a1 = 18'h020;
    #1;
    cyc();
    chk("t3_rereq",  sdram_if.sdram_req, 1'b1);
    chk("t3_readdr", sdram_if.sdram_addr, 22'h000018);
    sdram_if.sdram_ack = 1'b1;
    sdram_if.data_rdy  = 1'b1;
    sdram_if.data_read = 32'h7777_8888;
    cyc();
    sdram_if.sdram_ack = 1'b0;
    sdram_if.data_rdy  = 1'b0;
    chk("t3_ok1",   ok1, 1'b1);
    chk("t3_dout1", dout1, 16'h8888);

    // downloading during WAIT_RDY discards returned data
    cs1 = 1'b0; cs0 = 1'b1; a0 = 18'h200;
    cyc();
    chk("t4_addr", sdram_if.sdram_addr, 22'h100200);
    sdram_if.sdram_ack = 1'b1;
    cyc();
    sdram_if.sdram_ack = 1'b0;
    downloading = 1'b1;
    cyc();
    sdram_if.data_rdy  = 1'b1;
    sdram_if.data_read = 32'h9999_AAAA;
    cyc();
    sdram_if.data_rdy = 1'b0;
    chk("t4_ok0", ok0, 1'b0);
    chk("t4_req", sdram_if.sdram_req, 1'b0);
    cs1 = 1'b1; a1 = 18'h020;
    #1 chk("t4_ok1_flushed", ok1, 1'b0);
    cs1 = 1'b0;
    cyc();
    chk("t4_noreq_a", sdram_if.sdram_req, 1'b0);
    cyc();
    chk("t4_noreq_b", sdram_if.sdram_req, 1'b0);
    downloading = 1'b0;
    cyc();
    chk("t4_rereq",  sdram_if.sdram_req, 1'b1);
    chk("t4_readdr", sdram_if.sdram_addr, 22'h100200);
    sdram_if.sdram_ack = 1'b1;
    sdram_if.data_rdy  = 1'b1;
    sdram_if.data_read = 32'hBBBB_CCCC;
    cyc();
    sdram_if.sdram_ack = 1'b0;
    sdram_if.data_rdy  = 1'b0;
    chk("t4_ok0_end",   ok0, 1'b1);
    chk("t4_dout0_end", dout0, 16'hCCCC);

    // loop_rst aborts a pending request and flushes the caches
    a0 = 18'h300;
    cyc();
    chk("t5_req", sdram_if.sdram_req, 1'b1);
    chk("t5_addr", sdram_if.sdram_addr, 22'h100300);
    loop_rst = 1'b1;
    cyc();
    loop_rst = 1'b0;
    chk("t5_req_abort", sdram_if.sdram_req, 1'b0);
    a0 = 18'h200;
    #1 chk("t5_ok0_flushed", ok0, 1'b0);
    cyc();
    chk("t5_rereq",  sdram_if.sdram_req, 1'b1);
    chk("t5_readdr", sdram_if.sdram_addr, 22'h100200);

    // Asynchronous reset mid-transaction takes effect without a clock edge
    #2 rst = 1'b1;
    #1;
    chk("t6_req",   sdram_if.sdram_req, 1'b0);
    chk("t6_addr",  sdram_if.sdram_addr, 22'h0);
    chk("t6_bank",  sdram_if.sdram_bank, 2'd0);
    chk("t6_ok0",   ok0, 1'b0);
    chk("t6_dout0", dout0, 16'h0);
    chk("t6_dout1", dout1, 16'h0);
    cyc();
    rst = 1'b0;
    cs0 = 1'b0;
    cyc();
    chk("t6_idle", sdram_if.sdram_req, 1'b0);

`ifdef JTFRAME_ROMRQ_TIMEOUT_EN
    // Unanswered request: abandoned after 255 cycles, re-issued after one idle cycle
    cs0 = 1'b1; a0 = 18'h400;
    cyc();
    hi = 0;
    while (sdram_if.sdram_req && hi < 300) begin
      hi++;
      cyc();
    end
    chk("to_len", hi, 255);
    chk("to_drop", sdram_if.sdram_req, 1'b0);
    cyc();
    chk("to_rereq", sdram_if.sdram_req, 1'b1);
    cs0 = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
